// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// led_pattern_gen : prescaled LED pattern engine (blink / chase / bounce /
//                   PWM breathe) with a debounced DIP-switch overlay.
// Revision 1.0
// ============================================================================
module led_pattern_gen #(
  parameter int NUM_LEDS        = 8,
  parameter int TICK_DIV        = 12_500_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PWM_W           = 8,
  parameter int SW_LEDS         = 2
) (
  input  logic                clk_100m,
  input  logic                rst_n,
  input  logic [1:0]          mode_sel,
  input  logic                sw_in,
  output logic [NUM_LEDS-1:0] led,
  output logic                sw_db,
  output logic                tick
);

  localparam int POS_W = $clog2(NUM_LEDS);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic                sw_meta_q, sw_s_q;
  logic [1:0]          mode_meta_q, mode_s_q;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                sw_db_q, sw_db_d;
  mode_e               mode_q, mode_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic                phase_q, phase_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  dir_e                dir_q, dir_d;
  logic [PWM_W-1:0]    duty_q, duty_d;
  dir_e                ddir_q, ddir_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                mode_change;

  assign mode_change = (mode_s_q != mode_q);
  // A restart wins over a coincident tick, so the tick is masked here.
  assign tick  = (pre_cnt_q == PRE_LAST) && !mode_change;
  assign led   = led_q;
  assign sw_db = sw_db_q;

  always_comb begin
    db_cnt_d = '0;
    sw_db_d  = sw_db_q;
    if (sw_s_q != sw_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        sw_db_d = sw_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    mode_d    = mode_q;
    phase_d   = phase_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    duty_d    = duty_q;
    ddir_d    = ddir_q;
    if (mode_change) begin
      mode_d    = mode_e'(mode_s_q);
      pre_cnt_d = '0;
      phase_d   = 1'b0;
      pos_d     = '0;
      dir_d     = DIR_UP;
      duty_d    = '0;
      ddir_d    = DIR_UP;
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: phase_d = ~phase_q;
        MODE_CHASE: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            pos_d = pos_q + 1'b1;
            if (pos_d == POS_LAST) dir_d = DIR_DOWN;
          end else begin
            pos_d = pos_q - 1'b1;
            if (pos_d == '0) dir_d = DIR_UP;
          end
        end
        MODE_BREATHE: begin
          // End values are held for one tick while the direction turns.
          if (ddir_q == DIR_UP) begin
            if (duty_q == DUTY_MAX) ddir_d = DIR_DOWN;
            else                    duty_d = duty_q + 1'b1;
          end else begin
            if (duty_q == '0) ddir_d = DIR_UP;
            else              duty_d = duty_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_BLINK: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          led_d[i] = ((i % 2) == 1) ? phase_q : ~phase_q;
        end
      end
      MODE_CHASE, MODE_BOUNCE: led_d[pos_q] = 1'b1;
      MODE_BREATHE: led_d = {NUM_LEDS{pwm_cnt_q < duty_q}};
      default: ;
    endcase
    for (int i = 0; i < SW_LEDS; i++) begin
      led_d[i] = sw_db_q;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q   <= 1'b0;
      sw_s_q      <= 1'b0;
      mode_meta_q <= 2'd0;
      mode_s_q    <= 2'd0;
      db_cnt_q    <= '0;
      sw_db_q     <= 1'b0;
      mode_q      <= MODE_BLINK;
      pre_cnt_q   <= '0;
      phase_q     <= 1'b0;
      pos_q       <= '0;
      dir_q       <= DIR_UP;
      duty_q      <= '0;
      ddir_q      <= DIR_UP;
      pwm_cnt_q   <= '0;
      led_q       <= '0;
    end else begin
      sw_meta_q   <= sw_in;
      sw_s_q      <= sw_meta_q;
      mode_meta_q <= mode_sel;
      mode_s_q    <= mode_meta_q;
      db_cnt_q    <= db_cnt_d;
      sw_db_q     <= sw_db_d;
      mode_q      <= mode_d;
      pre_cnt_q   <= pre_cnt_d;
      phase_q     <= phase_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      duty_q      <= duty_d;
      ddir_q      <= ddir_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
    end
  end

endmodule
`default_nettype wire
